// File: rtl/id_ex_alu_stage_if.sv
// ID-to-EX boundary bundle: decoded ID fields in, registered EX-side controls/operands out.
// The master modport is the ID/hazard side; the slave modport is the stage register itself.
interface id_ex_alu_stage_if #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5,
    parameter int CNTW  = 16
);
    logic             Stall;
    logic             Flush;
    logic             InValid;
    logic             InRegWrite;
    logic             InMemRead;
    logic             InMemWrite;
    logic             InMemToReg;
    logic             InALUSrc;
    logic             InRegDst;
    logic [1:0]       InALUOp;
    logic [5:0]       InFunct;
    logic [WIDTH-1:0] InReadData1;
    logic [WIDTH-1:0] InReadData2;
    logic [WIDTH-1:0] InSignExt;
    logic [RADDR-1:0] InRt;
    logic [RADDR-1:0] InRd;

    logic             ExValid;
    logic [1:0]       ExSel;
    logic             ExInvertB;
    logic             ExCin;
    logic             ExSetLess;
    logic [WIDTH-1:0] ExDataA;
    logic [WIDTH-1:0] ExDataB;
    logic [WIDTH-1:0] ExStoreData;
    logic [RADDR-1:0] ExWriteReg;
    logic             ExRegWrite;
    logic             ExMemRead;
    logic             ExMemWrite;
    logic             ExMemToReg;
    logic             ExIllegal;
    logic [CNTW-1:0]  BubbleCount;

    modport master (
        output Stall, Flush, InValid, InRegWrite, InMemRead, InMemWrite, InMemToReg,
               InALUSrc, InRegDst, InALUOp, InFunct, InReadData1, InReadData2,
               InSignExt, InRt, InRd,
        input  ExValid, ExSel, ExInvertB, ExCin, ExSetLess, ExDataA, ExDataB,
               ExStoreData, ExWriteReg, ExRegWrite, ExMemRead, ExMemWrite,
               ExMemToReg, ExIllegal, BubbleCount
    );

    modport slave (
        input  Stall, Flush, InValid, InRegWrite, InMemRead, InMemWrite, InMemToReg,
               InALUSrc, InRegDst, InALUOp, InFunct, InReadData1, InReadData2,
               InSignExt, InRt, InRd,
        output ExValid, ExSel, ExInvertB, ExCin, ExSetLess, ExDataA, ExDataB,
               ExStoreData, ExWriteReg, ExRegWrite, ExMemRead, ExMemWrite,
               ExMemToReg, ExIllegal, BubbleCount
    );
endinterface

// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register with ALU-control decode, operand/destination muxing,
// stall/flush handling and a saturating count of inserted bubbles.
module id_ex_alu_stage #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    id_ex_alu_stage_if.slave     bus
);

    logic [1:0]       w_sel;
    logic             w_invert_b;
    logic             w_cin;
    logic             w_set_less;
    logic             w_legal;
    logic             w_bubble_in;
    logic [WIDTH-1:0] w_data_b;
    logic [RADDR-1:0] w_write_reg;
    logic [CNTW-1:0]  w_count_inc;

    logic             r_valid;
    logic [1:0]       r_sel;
    logic             r_invert_b;
    logic             r_cin;
    logic             r_set_less;
    logic [WIDTH-1:0] r_data_a;
    logic [WIDTH-1:0] r_data_b;
    logic [WIDTH-1:0] r_store_data;
    logic [RADDR-1:0] r_write_reg;
    logic             r_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_mem_to_reg;
    logic             r_illegal;
    logic [CNTW-1:0]  r_bubble_count;

    // ALUOp/funct to ALU slice controls; anything off the table is flagged illegal
    always_comb begin
        w_sel      = 2'b10;
        w_invert_b = 1'b0;
        w_cin      = 1'b0;
        w_set_less = 1'b0;
        w_legal    = 1'b1;
        case (bus.InALUOp)
            2'b00: begin
                w_sel = 2'b10;
            end
            2'b01: begin
                w_invert_b = 1'b1;
                w_cin      = 1'b1;
            end
            2'b10: begin
                case (bus.InFunct)
                    6'b100000: w_sel = 2'b10;
                    6'b100010: begin
                        w_invert_b = 1'b1;
                        w_cin      = 1'b1;
                    end
                    6'b100100: w_sel = 2'b00;
                    6'b100101: w_sel = 2'b01;
                    6'b101010: begin
                        w_invert_b = 1'b1;
                        w_cin      = 1'b1;
                        w_set_less = 1'b1;
                    end
                    default:   w_legal = 1'b0;
                endcase
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // Operand/destination muxes and saturating bubble increment
    always_comb begin
        w_bubble_in = !bus.InValid || !w_legal;
        if (bus.InALUSrc) begin
            w_data_b = bus.InSignExt;
        end else begin
            w_data_b = bus.InReadData2;
        end
        if (bus.InRegDst) begin
            w_write_reg = bus.InRd;
        end else begin
            w_write_reg = bus.InRt;
        end
        if (r_bubble_count == {CNTW{1'b1}}) begin
            w_count_inc = r_bubble_count;
        end else begin
            w_count_inc = r_bubble_count + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    // Stage register: reset > flush/bubble > stall > load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid        <= 1'b0;
            r_sel          <= 2'b00;
            r_invert_b     <= 1'b0;
            r_cin          <= 1'b0;
            r_set_less     <= 1'b0;
            r_data_a       <= {WIDTH{1'b0}};
            r_data_b       <= {WIDTH{1'b0}};
            r_store_data   <= {WIDTH{1'b0}};
            r_write_reg    <= {RADDR{1'b0}};
            r_reg_write    <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_to_reg   <= 1'b0;
            r_illegal      <= 1'b0;
            r_bubble_count <= {CNTW{1'b0}};
        end else if (bus.Flush || (!bus.Stall && w_bubble_in)) begin
            r_valid        <= 1'b0;
            r_sel          <= 2'b00;
            r_invert_b     <= 1'b0;
            r_cin          <= 1'b0;
            r_set_less     <= 1'b0;
            r_data_a       <= {WIDTH{1'b0}};
            r_data_b       <= {WIDTH{1'b0}};
            r_store_data   <= {WIDTH{1'b0}};
            r_write_reg    <= {RADDR{1'b0}};
            r_reg_write    <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_to_reg   <= 1'b0;
            // Only a real, unstalled, unflushed instruction can raise the illegal pulse
            r_illegal      <= !bus.Flush && bus.InValid && !w_legal;
            r_bubble_count <= w_count_inc;
        end else if (bus.Stall) begin
            r_illegal      <= 1'b0;
        end else begin
            r_valid        <= 1'b1;
            r_sel          <= w_sel;
            r_invert_b     <= w_invert_b;
            r_cin          <= w_cin;
            r_set_less     <= w_set_less;
            r_data_a       <= bus.InReadData1;
            r_data_b       <= w_data_b;
            r_store_data   <= bus.InReadData2;
            r_write_reg    <= w_write_reg;
            r_reg_write    <= bus.InRegWrite;
            r_mem_read     <= bus.InMemRead;
            r_mem_write    <= bus.InMemWrite;
            r_mem_to_reg   <= bus.InMemToReg;
            r_illegal      <= 1'b0;
        end
    end

    assign bus.ExValid     = r_valid;
    assign bus.ExSel       = r_sel;
    assign bus.ExInvertB   = r_invert_b;
    assign bus.ExCin       = r_cin;
    assign bus.ExSetLess   = r_set_less;
    assign bus.ExDataA     = r_data_a;
    assign bus.ExDataB     = r_data_b;
    assign bus.ExStoreData = r_store_data;
    assign bus.ExWriteReg  = r_write_reg;
    assign bus.ExRegWrite  = r_reg_write;
    assign bus.ExMemRead   = r_mem_read;
    assign bus.ExMemWrite  = r_mem_write;
    assign bus.ExMemToReg  = r_mem_to_reg;
    assign bus.ExIllegal   = r_illegal;
    assign bus.BubbleCount = r_bubble_count;

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Directed bench for id_ex_alu_stage; a second narrow-counter instance exercises saturation.
module tb_id_ex_alu_stage;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    id_ex_alu_stage_if #(.WIDTH(32), .RADDR(5), .CNTW(16)) bus ();
    id_ex_alu_stage_if #(.WIDTH(32), .RADDR(5), .CNTW(3))  sbus ();

    id_ex_alu_stage #(.WIDTH(32), .RADDR(5), .CNTW(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    id_ex_alu_stage #(.WIDTH(32), .RADDR(5), .CNTW(3)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] fn,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] se,
                             input logic src, input logic dst, input logic [4:0] rt,
                             input logic [4:0] rd);
        bus.InValid     = 1'b1;
        bus.InALUOp     = op;
        bus.InFunct     = fn;
        bus.InReadData1 = a;
        bus.InReadData2 = b;
        bus.InSignExt   = se;
        bus.InALUSrc    = src;
        bus.InRegDst    = dst;
        bus.InRt        = rt;
        bus.InRd        = rd;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.Stall = 1'b0;  bus.Flush = 1'b0;
        bus.InRegWrite = 1'b1; bus.InMemRead = 1'b0; bus.InMemWrite = 1'b0; bus.InMemToReg = 1'b0;
        set_instr(2'b00, 6'b000000, 32'h0000_0011, 32'h0000_0022, 32'h0000_0033,
                  1'b0, 1'b1, 5'd1, 5'd2);
        sbus.Stall = 1'b0; sbus.Flush = 1'b1; sbus.InValid = 1'b0;
        sbus.InRegWrite = 1'b0; sbus.InMemRead = 1'b0; sbus.InMemWrite = 1'b0;
        sbus.InMemToReg = 1'b0; sbus.InALUSrc = 1'b0; sbus.InRegDst = 1'b0;
        sbus.InALUOp = 2'b00; sbus.InFunct = 6'b000000; sbus.InReadData1 = 32'h0;
        sbus.InReadData2 = 32'h0; sbus.InSignExt = 32'h0; sbus.InRt = 5'd0; sbus.InRd = 5'd0;

        // Reset held two cycles with a valid instruction presented
        step(); step();
        chk("rst_valid", {63'd0, bus.ExValid}, 64'd0);
        chk("rst_sel", {62'd0, bus.ExSel}, 64'd0);
        chk("rst_dataa", {32'd0, bus.ExDataA}, 64'd0);
        chk("rst_datab", {32'd0, bus.ExDataB}, 64'd0);
        chk("rst_wreg", {59'd0, bus.ExWriteReg}, 64'd0);
        chk("rst_regwr", {63'd0, bus.ExRegWrite}, 64'd0);
        chk("rst_illegal", {63'd0, bus.ExIllegal}, 64'd0);
        chk("rst_bcount", {48'd0, bus.BubbleCount}, 64'd0);

        // R-type sub
        rst_n = 1'b1;
        set_instr(2'b10, 6'b100010, 32'd5, 32'd3, 32'h0000_0099, 1'b0, 1'b1, 5'd2, 5'd7);
        step();
        chk("sub_sel", {62'd0, bus.ExSel}, 64'd2);
        chk("sub_invb", {63'd0, bus.ExInvertB}, 64'd1);
        chk("sub_cin", {63'd0, bus.ExCin}, 64'd1);
        chk("sub_slt", {63'd0, bus.ExSetLess}, 64'd0);
        chk("sub_wreg", {59'd0, bus.ExWriteReg}, 64'd7);
        chk("sub_valid", {63'd0, bus.ExValid}, 64'd1);
        chk("sub_dataa", {32'd0, bus.ExDataA}, 64'd5);
        chk("sub_datab", {32'd0, bus.ExDataB}, 64'd3);
        chk("sub_store", {32'd0, bus.ExStoreData}, 64'd3);
        chk("sub_regwr", {63'd0, bus.ExRegWrite}, 64'd1);

        // I-type add (load-style) with negative immediate
        set_instr(2'b00, 6'b101010, 32'h0000_0010, 32'h0000_1234, 32'hFFFF_FFFC,
                  1'b1, 1'b0, 5'd9, 5'd7);
        bus.InRegWrite = 1'b1; bus.InMemRead = 1'b1; bus.InMemToReg = 1'b1;
        step();
        chk("addi_datab", {32'd0, bus.ExDataB}, 64'hFFFF_FFFC);
        chk("addi_wreg", {59'd0, bus.ExWriteReg}, 64'd9);
        chk("addi_sel", {62'd0, bus.ExSel}, 64'd2);
        chk("addi_invb", {63'd0, bus.ExInvertB}, 64'd0);
        chk("addi_slt", {63'd0, bus.ExSetLess}, 64'd0);
        chk("addi_store", {32'd0, bus.ExStoreData}, 64'h1234);
        chk("addi_memrd", {63'd0, bus.ExMemRead}, 64'd1);
        chk("addi_m2r", {63'd0, bus.ExMemToReg}, 64'd1);

        // Stall three cycles while inputs change (legal, illegal, invalid)
        bus.Stall = 1'b1;
        set_instr(2'b10, 6'b100100, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0, 1'b0, 1'b1, 5'd3, 5'd4);
        step();
        chk("stall1_datab", {32'd0, bus.ExDataB}, 64'hFFFF_FFFC);
        chk("stall1_dataa", {32'd0, bus.ExDataA}, 64'h10);
        set_instr(2'b10, 6'b000111, 32'h1, 32'h2, 32'h3, 1'b0, 1'b1, 5'd5, 5'd6);
        step();
        chk("stall2_wreg", {59'd0, bus.ExWriteReg}, 64'd9);
        chk("stall2_illegal", {63'd0, bus.ExIllegal}, 64'd0);
        bus.InValid = 1'b0;
        step();
        chk("stall3_valid", {63'd0, bus.ExValid}, 64'd1);
        chk("stall3_sel", {62'd0, bus.ExSel}, 64'd2);
        chk("stall3_bcount", {48'd0, bus.BubbleCount}, 64'd0);

        // Flush wins over stall
        set_instr(2'b00, 6'b0, 32'h7, 32'h8, 32'h9, 1'b0, 1'b0, 5'd1, 5'd2);
        bus.InRegWrite = 1'b1; bus.Flush = 1'b1;
        step();
        chk("flush_valid", {63'd0, bus.ExValid}, 64'd0);
        chk("flush_regwr", {63'd0, bus.ExRegWrite}, 64'd0);
        chk("flush_datab", {32'd0, bus.ExDataB}, 64'd0);
        chk("flush_memrd", {63'd0, bus.ExMemRead}, 64'd0);
        chk("flush_bcount", {48'd0, bus.BubbleCount}, 64'd1);

        // Remaining decode rows: and, or, ALUOp sub, slt
        bus.Flush = 1'b0; bus.Stall = 1'b0;
        set_instr(2'b10, 6'b100100, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 5'd1, 5'd2);
        step();
        chk("and_sel", {62'd0, bus.ExSel}, 64'd0);
        chk("and_invb", {63'd0, bus.ExInvertB}, 64'd0);
        bus.InFunct = 6'b100101;
        step();
        chk("or_sel", {62'd0, bus.ExSel}, 64'd1);
        bus.InALUOp = 2'b01;
        step();
        chk("op01_ctl", {61'd0, bus.ExSel, bus.ExInvertB, bus.ExCin, bus.ExSetLess}, 64'b10110);
        bus.InALUOp = 2'b10; bus.InFunct = 6'b101010;
        step();
        chk("slt_ctl", {61'd0, bus.ExSel, bus.ExInvertB, bus.ExCin, bus.ExSetLess}, 64'b10111);
        chk("slt_bcount", {48'd0, bus.BubbleCount}, 64'd1);

        // Illegal funct: one-cycle pulse plus bubble
        bus.InFunct = 6'b000111;
        step();
        chk("ill_pulse", {63'd0, bus.ExIllegal}, 64'd1);
        chk("ill_valid", {63'd0, bus.ExValid}, 64'd0);
        chk("ill_sel", {62'd0, bus.ExSel}, 64'd0);
        chk("ill_bcount", {48'd0, bus.BubbleCount}, 64'd2);
        bus.InALUOp = 2'b00;
        step();
        chk("ill_end", {63'd0, bus.ExIllegal}, 64'd0);
        chk("ill_next_valid", {63'd0, bus.ExValid}, 64'd1);

        // ALUOp 11 illegal, then stalled with the same illegal input, then invalid
        bus.InALUOp = 2'b11;
        step();
        chk("op11_pulse", {63'd0, bus.ExIllegal}, 64'd1);
        chk("op11_bcount", {48'd0, bus.BubbleCount}, 64'd3);
        bus.Stall = 1'b1;
        step();
        chk("op11_stall_ill", {63'd0, bus.ExIllegal}, 64'd0);
        chk("op11_stall_bc", {48'd0, bus.BubbleCount}, 64'd3);
        bus.Stall = 1'b0; bus.InALUOp = 2'b00; bus.InValid = 1'b0;
        step();
        chk("inval_ill", {63'd0, bus.ExIllegal}, 64'd0);
        chk("inval_bcount", {48'd0, bus.BubbleCount}, 64'd4);

        // Reset mid-stall clears everything
        bus.InValid = 1'b1; bus.Stall = 1'b1; rst_n = 1'b0;
        step();
        chk("rst2_bcount", {48'd0, bus.BubbleCount}, 64'd0);
        chk("rst2_wreg", {59'd0, bus.ExWriteReg}, 64'd0);
        chk("small_rst", {61'd0, sbus.BubbleCount}, 64'd0);

        // Continuous bubbles: narrow counter saturates at 7, wide one keeps counting
        rst_n = 1'b1; bus.Stall = 1'b0; bus.InValid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("small_six", {61'd0, sbus.BubbleCount}, 64'd6);
        step();
        chk("small_sat", {61'd0, sbus.BubbleCount}, 64'd7);
        for (int i = 0; i < 3; i++) step();
        chk("small_hold", {61'd0, sbus.BubbleCount}, 64'd7);
        chk("wide_ten", {48'd0, bus.BubbleCount}, 64'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
